// File: rtl/truth_table_checker.sv
// Response checker for exhaustive truth-table runs: accepts applied vectors, samples DUT outputs after a settle delay, compares them with a golden table.
// Optional macro CHECKER_HALT_ON_ERR_EN: stop the run (DONE, pass=0) on the first mismatch.
module truth_table_checker #(
   parameter int N_IN = 4,
   parameter int N_OUT = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 32'hE4E4E4E4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN-1:0]      in_vec,
   input  logic [N_OUT-1:0]     resp,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic                 first_err_valid,
   output logic [N_IN-1:0]      first_err_vec,
   output logic [(2**N_IN)-1:0] cov
);

   localparam int N_VEC = 2**N_IN;
   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [N_VEC-1:0]  cov_q, cov_d;
   logic [N_IN:0]     err_q, err_d;
   logic              fev_q, fev_d;
   logic [N_IN-1:0]   fvec_q, fvec_d;
   logic [N_OUT-1:0]  exp_resp;
   logic              mismatch;

   assign exp_resp = EXPECTED[int'(vec_q)*N_OUT +: N_OUT];
   assign mismatch = (resp != exp_resp);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      cov_d   = cov_q;
      err_d   = err_q;
      fev_d   = fev_q;
      fvec_d  = fvec_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               cov_d   = '0;
               err_d   = '0;
               fev_d   = 1'b0;
               fvec_d  = '0;
            end
         end
         RUN: begin
            if (in_valid) begin
               vec_d   = in_vec;
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               // Sample edge: the latched vector's response is judged exactly once here
               cov_d = cov_q | (N_VEC'(1) << vec_q);
               if (mismatch) begin
                  if (err_q != '1) err_d = err_q + 1'b1;
                  if (!fev_q) begin
                     fev_d  = 1'b1;
                     fvec_d = vec_q;
                  end
               end
`ifdef CHECKER_HALT_ON_ERR_EN
               if (mismatch || (&cov_d)) state_d = DONE;
               else                      state_d = RUN;
`else
               if (&cov_d) state_d = DONE;
               else        state_d = RUN;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         cov_q   <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fvec_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         cov_q   <= cov_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fvec_q  <= fvec_d;
      end
   end

   assign in_ready        = (state_q == RUN);
   assign busy            = (state_q == RUN) || (state_q == SETTLE);
   assign done            = (state_q == DONE);
   assign pass            = (state_q == DONE) && (err_q == '0);
   assign err_cnt         = err_q;
   assign first_err_valid = fev_q;
   assign first_err_vec   = fvec_q;
   assign cov             = cov_q;

endmodule
